hit_detect: RTL
===============

// Module: hit_detect
// PURPOSE
//  Upstream stage of the hit ring counter. Smooths the raw ADC sample stream with a power-of-2 moving average.
//  Presents the result as sm_data/sm_vld.
//  Runs the hit/lock window state machine that drives stu_now_hit/stu_now_lock for the ring counter and the register file.
//  Also keeps a saturating count of detected hits for status readback.
// PARAMETERS
//  SM_SHIFT  2  moving-average window = 2**SM_SHIFT samples (legal 1..4)
// PORTS
//  clk_sys       in   1   system clock
//  rst_n         in   1   asynchronous active-low reset
//  ad_data       in   16  raw unsigned ADC sample
//  ad_vld        in   1   ad_data valid, single-cycle strobe, any rate up to every cycle
//  cfg_th_hit    in   16  hit threshold on smoothed data (unsigned compare, >=)
//  cfg_hit_len   in   16  consecutive smoothed samples >= threshold needed to start a hit (0 treated as 1)
//  cfg_end_len   in   16  consecutive smoothed samples < threshold needed to end a hit (0 treated as 1)
//  cfg_lock_len  in   16  smoothed samples spent in LOCK after a hit (0 = one clk_sys cycle in LOCK)
//  force_end     in   1   level; while high, HIT ends immediately
//  sm_data       out  16  smoothed sample; holds between strobes
//  sm_vld        out  1   sm_data valid strobe
//  stu_now_hit   out  1   high while state = HIT
//  stu_now_lock  out  1   high while state = LOCK
//  stu_hit_cnt   out  16  number of IDLE->HIT transitions since reset, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset values: all outputs 0, delay line 0, sum 0, state IDLE, all counters 0.
//  Smoother:
//   - Keeps a 2**SM_SHIFT-deep delay line and a running sum of 16+SM_SHIFT bits.
//   - On ad_vld: sum <= sum + ad_data - oldest; shift ad_data into the line.
//   - sm_data <= (sum + ad_data - oldest) >> SM_SHIFT, so the new average is visible on the next cycle.
//   - sm_vld is ad_vld delayed by exactly 1 cycle.
//   - No overflow is possible. The first 2**SM_SHIFT-1 outputs after reset are averages against zeros.
//  Compare:
//   - above = (sm_data >= cfg_th_hit), evaluated only in cycles where sm_vld=1.
//   - cfg_* are sampled live and must be static while state != IDLE.
//  FSM (registered; decision on the sm_vld cycle, new state visible the next cycle):
//   - IDLE:
//     - run_cnt counts consecutive 'above' samples; a below sample clears it.
//     - When run_cnt+1 >= max(cfg_hit_len,1) on an above sample: go HIT, clear run_cnt, increment stu_hit_cnt (saturating).
//   - HIT:
//     - run_cnt counts consecutive below samples; an above sample clears it.
//     - When run_cnt+1 >= max(cfg_end_len,1) on a below sample: go LOCK, clear run_cnt.
//     - force_end=1 in any HIT cycle: go LOCK next cycle regardless of sm_vld; force_end has priority over the run count.
//   - LOCK:
//     - lock_cnt counts sm_vld strobes; at lock_cnt+1 >= cfg_lock_len: go IDLE and clear lock_cnt.
//     - cfg_lock_len=0: return to IDLE on the cycle after entering LOCK.
//     - force_end is ignored in LOCK and IDLE.
//  stu_now_hit/stu_now_lock are decoded from registered state; they are never both high.
//   - A hit always produces HIT then LOCK. The falling edge of stu_now_hit coincides with the rise of stu_now_lock.
//  Reset mid-operation: asynchronously returns to IDLE and drops hit/lock the same cycle.
//   - No ph_vld-style end strobe is generated downstream by this reset.
//  Counter widths: run_cnt and lock_cnt are 16 bit and cannot wrap, because the compare terminates them at the cfg value.
// TESTING
//  1. Reset, SM_SHIFT=2, ad_vld every cycle, ad_data=400 constant.
//     -> sm_data sequence 100,200,300,400,400..., each 1 cycle after ad_vld.
//  2. cfg_th_hit=300, cfg_hit_len=3, cfg_end_len=2, cfg_lock_len=4; feed a step to 400, then a step to 0.
//     -> stu_now_hit rises the cycle after the 3rd smoothed sample >=300.
//     -> Falls after the 2nd sample <300; stu_now_lock is high for exactly 4 strobes; stu_hit_cnt=1.
//  3. Glitch: smoothed above for 2 samples, then below, with cfg_hit_len=3.
//     -> No HIT, stu_hit_cnt unchanged, run_cnt cleared.
//  4. force_end pulsed for 1 cycle mid-HIT with data still above.
//     -> LOCK next cycle, then IDLE after cfg_lock_len strobes, then a new hit is detectable.
//  5. cfg_hit_len=0, cfg_end_len=0, cfg_lock_len=0.
//     -> Behaves as 1,1 with a 1-cycle LOCK; preload 65535 hits (or force the counter) and check stu_hit_cnt saturates at 16'hFFFF.
//  6. Assert rst_n low while in HIT with ad_vld active.
//     -> All outputs 0 immediately; after release, sm_data restarts from a zero window (case 1 sequence).

Source files
------------

// File: rtl/hit_detect.sv
// Moving-average smoother plus IDLE/HIT/LOCK hit window FSM; sm_data lands 1 cycle after ad_vld, state 1 cycle after sm_vld.
// No backpressure: every ad_vld strobe is accepted; force_end ends HIT on the next cycle.
module hit_detect #(
  parameter int SM_SHIFT = 2
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [15:0] ad_data,
  input  logic        ad_vld,
  input  logic [15:0] cfg_th_hit,
  input  logic [15:0] cfg_hit_len,
  input  logic [15:0] cfg_end_len,
  input  logic [15:0] cfg_lock_len,
  input  logic        force_end,
  output logic [15:0] sm_data,
  output logic        sm_vld,
  output logic        stu_now_hit,
  output logic        stu_now_lock,
  output logic [15:0] stu_hit_cnt
);

  localparam int DEPTH = 2 ** SM_SHIFT;
  localparam int SW    = 16 + SM_SHIFT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIT  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  logic [15:0]   dly [DEPTH];
  logic [SW-1:0] sum;
  logic [SW-1:0] sum_nxt;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] run_cnt;
  logic [15:0] run_nxt;
  logic [15:0] lock_cnt;
  logic [15:0] lock_nxt;
  logic [15:0] hit_cnt;
  logic [15:0] hit_cnt_nxt;

  logic        above;
  logic [15:0] hit_need;
  logic [15:0] end_need;
  logic [16:0] run_inc;
  logic [16:0] lock_inc;

  // Sum never overflows: it holds at most DEPTH samples of 16 bits.
  assign sum_nxt = sum + {{SM_SHIFT{1'b0}}, ad_data} - {{SM_SHIFT{1'b0}}, dly[DEPTH-1]};

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        dly[i] <= '0;
      end
      sum     <= '0;
      sm_data <= '0;
      sm_vld  <= 1'b0;
    end else begin
      sm_vld <= ad_vld;
      if (ad_vld) begin
        dly[0] <= ad_data;
        for (int i = 1; i < DEPTH; i++) begin
          dly[i] <= dly[i-1];
        end
        sum     <= sum_nxt;
        sm_data <= sum_nxt[SW-1:SM_SHIFT];
      end
    end
  end

  assign above    = (sm_data >= cfg_th_hit);
  assign hit_need = (cfg_hit_len == 16'd0) ? 16'd1 : cfg_hit_len;
  assign end_need = (cfg_end_len == 16'd0) ? 16'd1 : cfg_end_len;
  assign run_inc  = {1'b0, run_cnt} + 17'd1;
  assign lock_inc = {1'b0, lock_cnt} + 17'd1;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      run_cnt  <= '0;
      lock_cnt <= '0;
      hit_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      run_cnt  <= run_nxt;
      lock_cnt <= lock_nxt;
      hit_cnt  <= hit_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    run_nxt     = run_cnt;
    lock_nxt    = lock_cnt;
    hit_cnt_nxt = hit_cnt;
    unique case (state)
      ST_IDLE: begin
        if (sm_vld) begin
          if (above) begin
            if (run_inc >= {1'b0, hit_need}) begin
              state_nxt = ST_HIT;
              run_nxt   = '0;
              if (hit_cnt != 16'hFFFF) begin
                hit_cnt_nxt = hit_cnt + 16'd1;
              end
            end else begin
              run_nxt = run_inc[15:0];
            end
          end else begin
            run_nxt = '0;
          end
        end
      end
      ST_HIT: begin
        // force_end wins over the below-run count and does not wait for a strobe.
        if (force_end) begin
          state_nxt = ST_LOCK;
          run_nxt   = '0;
        end else if (sm_vld) begin
          if (!above) begin
            if (run_inc >= {1'b0, end_need}) begin
              state_nxt = ST_LOCK;
              run_nxt   = '0;
            end else begin
              run_nxt = run_inc[15:0];
            end
          end else begin
            run_nxt = '0;
          end
        end
      end
      ST_LOCK: begin
        if (cfg_lock_len == 16'd0) begin
          state_nxt = ST_IDLE;
          lock_nxt  = '0;
        end else if (sm_vld) begin
          if (lock_inc >= {1'b0, cfg_lock_len}) begin
            state_nxt = ST_IDLE;
            lock_nxt  = '0;
          end else begin
            lock_nxt = lock_inc[15:0];
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        run_nxt   = '0;
        lock_nxt  = '0;
      end
    endcase
  end

  assign stu_now_hit  = (state == ST_HIT);
  assign stu_now_lock = (state == ST_LOCK);
  assign stu_hit_cnt  = hit_cnt;

endmodule
